// File: rtl/id_issue_unit_if.sv
// id_issue_unit_if: registered ID/EX pipeline bundle from the issue stage to EX, with EX back-pressure.
//   master (issue side) drives valid, reg_write, mem_read, ctrl, rs_data, rt_data, imm, rs, rt, dst
//   and samples ready; slave (EX side) is the mirror image.
interface id_issue_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 32
);
    logic              valid, reg_write, mem_read, ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rs_data, rt_data, imm;
    logic [REG_AW-1:0] rs, rt, dst;
    modport master (output valid, reg_write, mem_read, ctrl, rs_data, rt_data, imm, rs, rt, dst, input ready);
    modport slave (input valid, reg_write, mem_read, ctrl, rs_data, rt_data, imm, rs, rt, dst, output ready);
endinterface

// File: rtl/id_issue_unit.sv
// id_issue_unit: decode/issue stage with register file, ID forwarding, hazard stalls, branch/jump resolution and ID/EX register.
//   clk, rst_n (async, active-low)
//   ifid_*            instruction, valid and PC+4 from IF/ID
//   ctrl_in .. is_jump_reg  decoded control from the Control block
//   exmem_*, wb_*     forwarding sources; wb_* also writes the register file
//   pc_write, ifid_write, flush_if, redirect_valid, redirect_pc  combinational front-end control
//   stall_count       saturating hazard-stall counter
//   idex              ID/EX bundle (master), idex.ready is EX back-pressure
module id_issue_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifid_valid,
    input  logic [31:0]       ifid_instr,
    input  logic [DATA_W-1:0] ifid_pc_adder,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic [REG_AW-1:0] dst,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              zero_ext,
    input  logic              is_branch,
    input  logic [2:0]        branch_cond,
    input  logic              is_jump,
    input  logic              is_jump_reg,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [REG_AW-1:0] exmem_reg_dst,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_reg_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              flush_if,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  stall_count,
    id_issue_unit_if.master   idex
);
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic              valid, reg_write, mem_read;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rs_data, rt_data, imm;
        logic [REG_AW-1:0] rs, rt, dst;
    } idex_t;

    logic [DATA_W-1:0] rf [NUM_REGS];
    idex_t             q, d;
    logic [REG_AW-1:0] rs, rt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext, br_off;
    logic              hit_idex, hit_exmem, ctl_xfer, stall, issue, taken, lez, ltz, unused_bits;

    assign rs          = ifid_instr[21 +: REG_AW];
    assign rt          = ifid_instr[16 +: REG_AW];
    assign imm         = ifid_instr[15:0];
    assign unused_bits = ^ifid_instr[31:26];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        else if (wb_reg_write && wb_reg_dst != '0)
            rf[wb_reg_dst] <= wb_data;

    // EX/MEM wins over WB as the younger producer; a load in EX/MEM has no data yet.
    assign rs_val = rs == '0 ? '0 :
                    (exmem_reg_write && !exmem_mem_read && exmem_reg_dst == rs) ? exmem_data :
                    (wb_reg_write && wb_reg_dst == rs) ? wb_data : rf[rs];
    assign rt_val = rt == '0 ? '0 :
                    (exmem_reg_write && !exmem_mem_read && exmem_reg_dst == rt) ? exmem_data :
                    (wb_reg_write && wb_reg_dst == rt) ? wb_data : rf[rt];

    assign hit_idex  = (uses_rs && rs != '0 && q.dst == rs) || (uses_rt && rt != '0 && q.dst == rt);
    assign hit_exmem = (uses_rs && rs != '0 && exmem_reg_dst == rs) || (uses_rt && rt != '0 && exmem_reg_dst == rt);
    // Branches and JR resolve in ID, so they must also wait for ALU results in EX and loads in MEM.
    assign ctl_xfer  = is_branch || is_jump_reg;
    assign stall     = ifid_valid && ((q.valid && q.mem_read && hit_idex) ||
                                      (ctl_xfer && q.valid && q.reg_write && hit_idex) ||
                                      (ctl_xfer && exmem_reg_write && exmem_mem_read && hit_exmem));
    assign issue     = ifid_valid && !stall && idex.ready;

    assign imm_ext = zero_ext ? {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){imm[15]}}, imm};
    assign br_off  = {{(DATA_W-18){imm[15]}}, imm, 2'b00};
    assign ltz     = rs_val[DATA_W-1];
    assign lez     = ltz || rs_val == '0;
    assign taken   = branch_cond == 3'd0 ? rs_val == rt_val :
                     branch_cond == 3'd1 ? rs_val != rt_val :
                     branch_cond == 3'd2 ? lez :
                     branch_cond == 3'd3 ? !lez :
                     branch_cond == 3'd4 ? ltz :
                     branch_cond == 3'd5 ? !ltz : 1'b0;

    assign redirect_pc    = is_jump_reg ? rs_val :
                            is_jump ? {ifid_pc_adder[DATA_W-1:28], ifid_instr[25:0], 2'b00} :
                            ifid_pc_adder + br_off;
    assign redirect_valid = rst_n && issue && (is_jump || is_jump_reg || (is_branch && taken));
    assign flush_if       = redirect_valid;
    assign pc_write       = !rst_n || (idex.ready && !stall);
    assign ifid_write     = pc_write;

    always_comb begin
        d = '0;
        if (issue)
            d = '{1'b1, reg_write_in, mem_read_in, ctrl_in, rs_val, rt_val, imm_ext, rs, rt, dst};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q           <= '0;
            stall_count <= '0;
        end else if (idex.ready) begin
            q <= d;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end

    assign idex.valid     = q.valid;
    assign idex.reg_write = q.reg_write;
    assign idex.mem_read  = q.mem_read;
    assign idex.ctrl      = q.ctrl;
    assign idex.rs_data   = q.rs_data;
    assign idex.rt_data   = q.rt_data;
    assign idex.imm       = q.imm;
    assign idex.rs        = q.rs;
    assign idex.rt        = q.rt;
    assign idex.dst       = q.dst;
endmodule
